// File: rtl/cmd_parser_if.sv
// Request/response bundle between the UART byte source, the command parser and the ALU.
interface cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        alu_done;
  logic [3:0]  dtype;
  logic [4:0]  op;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        start;
  logic        busy;
  logic        cmd_done;
  logic        frame_err;

  modport master (
    output rx_data, rx_valid, alu_done,
    input  dtype, op, src1, src2, start, busy, cmd_done, frame_err
  );

  modport slave (
    input  rx_data, rx_valid, alu_done,
    output dtype, op, src1, src2, start, busy, cmd_done, frame_err
  );
endinterface

// File: rtl/cmd_parser.sv
// ASCII frame decoder "<W|S><4 hex><+-*/><4 hex>=" issuing one ALU request per frame
// and holding the issued operands until the ALU completes or the request times out.
module cmd_parser #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic         clk,
  input logic         n_rst,
  cmd_parser_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SRC1, S_OPR, S_SRC2, S_EQ, S_ISSUE, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    type_sh_q, type_sh_d;
  logic [4:0]    op_sh_q, op_sh_d;
  logic [15:0]   src1_sh_q, src1_sh_d;
  logic [15:0]   src2_sh_q, src2_sh_d;
  logic [3:0]    dtype_q, dtype_d;
  logic [4:0]    op_q, op_d;
  logic [15:0]   src1_q, src1_d;
  logic [15:0]   src2_q, src2_d;
  logic          cmd_done_q, cmd_done_d;
  logic          frame_err_q, frame_err_d;
  logic          perr;
  logic [4:0]    nib;

  // {valid, value} for one ASCII hex digit
  function automatic logic [4:0] hex_nib(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)
      return {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      return {1'b1, b[3:0] + 4'd9};
    else
      return 5'h00;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    type_sh_d   = type_sh_q;
    op_sh_d     = op_sh_q;
    src1_sh_d   = src1_sh_q;
    src2_sh_d   = src2_sh_q;
    dtype_d     = dtype_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    cmd_done_d  = 1'b0;
    frame_err_d = 1'b0;
    perr        = 1'b0;
    nib         = hex_nib(bus.rx_data);

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == 8'h57 || bus.rx_data == 8'h53)) begin
          type_sh_d = (bus.rx_data == 8'h57) ? 4'h1 : 4'h2;
          op_sh_d   = '0;
          src1_sh_d = '0;
          src2_sh_d = '0;
          cnt_d     = '0;
          state_d   = S_SRC1;
        end
      end
      S_SRC1: begin
        if (bus.rx_valid) begin
          if (nib[4]) begin
            src1_sh_d = {src1_sh_q[11:0], nib[3:0]};
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_OPR;
          end else begin
            perr = 1'b1;
          end
        end
      end
      S_OPR: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            8'h2B:   op_sh_d = 5'h01;
            8'h2D:   op_sh_d = 5'h02;
            8'h2A:   op_sh_d = 5'h04;
            8'h2F:   op_sh_d = 5'h08;
            default: perr    = 1'b1;
          endcase
          if (!perr) state_d = S_SRC2;
        end
      end
      S_SRC2: begin
        if (bus.rx_valid) begin
          if (nib[4]) begin
            src2_sh_d = {src2_sh_q[11:0], nib[3:0]};
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_EQ;
          end else begin
            perr = 1'b1;
          end
        end
      end
      S_EQ: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h3D) begin
            // outputs load on the edge that accepts '=' so they are valid with start
            dtype_d = type_sh_q;
            op_d    = op_sh_q;
            src1_d  = src1_sh_q;
            src2_d  = src2_sh_q;
            state_d = S_ISSUE;
          end else begin
            perr = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_done) begin
          cmd_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (perr) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
      cnt_d       = '0;
      type_sh_d   = '0;
      op_sh_d     = '0;
      src1_sh_d   = '0;
      src2_sh_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      type_sh_q   <= '0;
      op_sh_q     <= '0;
      src1_sh_q   <= '0;
      src2_sh_q   <= '0;
      dtype_q     <= '0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      cmd_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      type_sh_q   <= type_sh_d;
      op_sh_q     <= op_sh_d;
      src1_sh_q   <= src1_sh_d;
      src2_sh_q   <= src2_sh_d;
      dtype_q     <= dtype_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      cmd_done_q  <= cmd_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.dtype     = dtype_q;
  assign bus.op        = op_q;
  assign bus.src1      = src1_q;
  assign bus.src2      = src2_q;
  assign bus.start     = (state_q == S_ISSUE);
  assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.cmd_done  = cmd_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized self-checking bench for cmd_parser against a frame-level string model.
module tb_cmd_parser;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  cmd_parser_if bus ();

  cmd_parser #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // model: bytes of the frame in progress, plus last issued fields
  byte unsigned mbuf[$];
  bit           mbusy;
  logic [3:0]   e_dtype;
  logic [4:0]   e_op;
  logic [15:0]  e_src1, e_src2;

  function automatic int hexv(input byte unsigned b);
    if (b >= 48 && b <= 57)  return b - 48;
    if (b >= 65 && b <= 70)  return b - 55;
    if (b >= 97 && b <= 102) return b - 87;
    return -1;
  endfunction

  function automatic logic [4:0] op_code(input byte unsigned b);
    case (b)
      8'h2B:   return 5'h01;
      8'h2D:   return 5'h02;
      8'h2A:   return 5'h04;
      8'h2F:   return 5'h08;
      default: return 5'h00;
    endcase
  endfunction

  task automatic model_reset();
    mbuf.delete();
    mbusy   = 1'b0;
    e_dtype = '0;
    e_op    = '0;
    e_src1  = '0;
    e_src2  = '0;
  endtask

  task automatic model_byte(input byte unsigned b, output bit err, output bit iss);
    int pos;
    bit ok;
    err = 1'b0;
    iss = 1'b0;
    if (mbusy) return;
    if (mbuf.size() == 0) begin
      if (b == 8'h57 || b == 8'h53) mbuf.push_back(b);
      return;
    end
    pos = mbuf.size();
    if (pos == 5)       ok = (op_code(b) != 5'h00);
    else if (pos == 10) ok = (b == 8'h3D);
    else                ok = (hexv(b) >= 0);
    if (!ok) begin
      mbuf.delete();
      err = 1'b1;
      return;
    end
    mbuf.push_back(b);
    if (pos == 10) begin
      e_dtype = (mbuf[0] == 8'h57) ? 4'h1 : 4'h2;
      e_op    = op_code(mbuf[5]);
      e_src1  = '0;
      e_src2  = '0;
      for (int i = 1; i <= 4; i++) e_src1 = e_src1 * 16 + 16'(hexv(mbuf[i]));
      for (int i = 6; i <= 9; i++) e_src2 = e_src2 * 16 + 16'(hexv(mbuf[i]));
      mbuf.delete();
      mbusy = 1'b1;
      iss   = 1'b1;
    end
  endtask

  task automatic model_str(input string s, output logic [31:0] e, output logic [31:0] st);
    bit eb, ib;
    e  = '0;
    st = '0;
    for (int i = 0; i < s.len(); i++) begin
      model_byte(s[i], eb, ib);
      e[i]  = eb;
      st[i] = ib;
    end
  endtask

  // one byte per cycle; frame_err/start recorded in the cycle after each byte's edge
  task automatic send_str(input string s, input bit now,
                          output logic [31:0] e, output logic [31:0] st);
    e  = '0;
    st = '0;
    for (int i = 0; i < s.len(); i++) begin
      if (!(now && i == 0)) @(negedge clk);
      if (i > 0) begin
        e[i-1]  = bus.frame_err;
        st[i-1] = bus.start;
      end
      bus.rx_data  = s[i];
      bus.rx_valid = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid   = 1'b0;
    e[s.len()-1]  = bus.frame_err;
    st[s.len()-1] = bus.start;
  endtask

  task automatic do_done(input int gap, output logic cd, output logic bz, output logic fe);
    repeat (gap) @(negedge clk);
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    cd = bus.cmd_done;
    bz = bus.busy;
    fe = bus.frame_err;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err} !== 45'h0)
      begin bad++; $display("FAIL reset_outputs got=%h exp=0",
        {bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err}); end
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic(input string s, input string name);
    logic [31:0] me, ms, ge, gs;
    logic cd, bz, fe;
    model_str(s, me, ms);
    send_str(s, 1'b0, ge, gs);
    total++;
    if (ge !== me) begin bad++; $display("FAIL %s_err got=%h exp=%h", name, ge, me); end
    total++;
    if (gs !== ms) begin bad++; $display("FAIL %s_start got=%h exp=%h", name, gs, ms); end
    total++;
    if ({bus.dtype, bus.op, bus.src1, bus.src2} !== {e_dtype, e_op, e_src1, e_src2})
      begin bad++; $display("FAIL %s_fields got=%h exp=%h", name,
        {bus.dtype, bus.op, bus.src1, bus.src2}, {e_dtype, e_op, e_src1, e_src2}); end
    @(negedge clk);
    total++;
    if ({bus.start, bus.busy} !== 2'b01)
      begin bad++; $display("FAIL %s_single_start got=%b exp=01", name, {bus.start, bus.busy}); end
    do_done(2, cd, bz, fe);
    mbusy = 1'b0;
    total++;
    if ({cd, bz, fe} !== 3'b100) begin bad++; $display("FAIL %s_done got=%b exp=100", name, {cd, bz, fe}); end
    @(negedge clk);
    total++;
    if (bus.cmd_done !== 1'b0) begin bad++; $display("FAIL %s_done_once got=%b exp=0", name, bus.cmd_done); end
  endtask

  task automatic test_parse_error();
    logic [31:0] me, ms, ge, gs;
    logic [40:0] prev;
    prev = {e_dtype, e_op, e_src1, e_src2};
    model_str("W00G", me, ms);
    send_str("W00G", 1'b0, ge, gs);
    total++;
    if (ge !== me || me !== 32'h8) begin bad++; $display("FAIL perr_pulse got=%h exp=%h", ge, me); end
    total++;
    if (gs !== 32'h0) begin bad++; $display("FAIL perr_no_start got=%h exp=0", gs); end
    @(negedge clk);
    total++;
    if ({bus.frame_err, bus.dtype, bus.op, bus.src1, bus.src2} !== {1'b0, prev})
      begin bad++; $display("FAIL perr_hold got=%h exp=%h",
        {bus.frame_err, bus.dtype, bus.op, bus.src1, bus.src2}, {1'b0, prev}); end
    test_basic("W1234-0FED=", "after_err");
  endtask

  task automatic test_crlf_and_drop();
    logic [31:0] me, ms, ge, gs;
    logic [40:0] held;
    logic cd, bz, fe;
    model_str("\r\nW0002*0003=", me, ms);
    send_str("\r\nW0002*0003=", 1'b0, ge, gs);
    total++;
    if (ge !== 32'h0 || gs !== ms) begin bad++; $display("FAIL crlf got=%h/%h exp=0/%h", ge, gs, ms); end
    total++;
    if (bus.op !== e_op || e_op !== 5'h04) begin bad++; $display("FAIL crlf_op got=%h exp=%h", bus.op, e_op); end
    held = {e_dtype, e_op, e_src1, e_src2};
    model_str("W1111+1111=", me, ms);
    send_str("W1111+1111=", 1'b0, ge, gs);
    total++;
    if ({ge, gs} !== {me, ms}) begin bad++; $display("FAIL drop_busy got=%h exp=%h", {ge, gs}, {me, ms}); end
    total++;
    if ({bus.busy, bus.dtype, bus.op, bus.src1, bus.src2} !== {1'b1, held})
      begin bad++; $display("FAIL drop_hold got=%h exp=%h",
        {bus.busy, bus.dtype, bus.op, bus.src1, bus.src2}, {1'b1, held}); end
    do_done(1, cd, bz, fe);
    mbusy = 1'b0;
    total++;
    if ({cd, bz} !== 2'b10) begin bad++; $display("FAIL drop_done got=%b exp=10", {cd, bz}); end
  endtask

  task automatic test_timeout();
    logic [31:0] me, ms, ge, gs;
    logic cd, bz, fe;
    int k;
    model_str("W0001+0001=", me, ms);
    send_str("W0001+0001=", 1'b0, ge, gs);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.frame_err) begin k = i; break; end
    end
    mbusy = 1'b0;
    total++;
    if (k !== 17) begin bad++; $display("FAIL timeout_cycles got=%0d exp=17", k); end
    total++;
    if ({bus.busy, bus.cmd_done} !== 2'b00) begin bad++; $display("FAIL timeout_busy got=%b exp=00", {bus.busy, bus.cmd_done}); end
    model_str("S8000*0002=", me, ms);
    send_str("S8000*0002=", 1'b0, ge, gs);
    total++;
    if (gs !== ms || ms !== 32'h400) begin bad++; $display("FAIL after_timeout got=%h exp=%h", gs, ms); end
    // alu_done on the last WAIT cycle beats the timeout
    do_done(16, cd, bz, fe);
    mbusy = 1'b0;
    total++;
    if ({cd, bz, fe} !== 3'b100) begin bad++; $display("FAIL done_vs_timeout got=%b exp=100", {cd, bz, fe}); end
    @(negedge clk);
    total++;
    if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL done_vs_timeout_err got=%b exp=0", bus.frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] me, ms, ge, gs;
    logic cd, bz, fe;
    do_done(1, cd, bz, fe);
    total++;
    if (cd !== 1'b0) begin bad++; $display("FAIL idle_done_ignored got=%b exp=0", cd); end
    model_str("Wabcd-0001=", me, ms);
    send_str("Wabcd-0001=", 1'b0, ge, gs);
    do_done(4, cd, bz, fe);
    mbusy = 1'b0;
    model_str("W0010/0004=", me, ms);
    send_str("W0010/0004=", 1'b1, ge, gs);
    total++;
    if ({ge, gs} !== {me, ms}) begin bad++; $display("FAIL b2b got=%h exp=%h", {ge, gs}, {me, ms}); end
    total++;
    if ({bus.dtype, bus.op, bus.src1, bus.src2} !== {e_dtype, e_op, e_src1, e_src2})
      begin bad++; $display("FAIL b2b_fields got=%h exp=%h",
        {bus.dtype, bus.op, bus.src1, bus.src2}, {e_dtype, e_op, e_src1, e_src2}); end
    do_done(1, cd, bz, fe);
    mbusy = 1'b0;
  endtask

  task automatic test_random();
    string hx, ops, s;
    logic [31:0] me, ms, ge, gs;
    logic cd, bz, fe;
    hx  = "0123456789ABCDEFabcdef";
    ops = "+-*/";
    for (int n = 0; n < 24; n++) begin
      s = ($urandom_range(0, 3) == 0) ? "\nW0000+0000=" : "W0000+0000=";
      for (int p = s.len() - 11; p < s.len(); p++) begin
        int q;
        q = p - (s.len() - 11);
        if (q == 0)      s.putc(p, ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h53);
        else if (q == 5) s.putc(p, ops[$urandom_range(0, 3)]);
        else if (q != 10) s.putc(p, hx[$urandom_range(0, 21)]);
      end
      if ($urandom_range(0, 3) == 0)
        s.putc(s.len() - 11 + $urandom_range(1, 10), 8'($urandom_range(0, 255)));
      model_str(s, me, ms);
      send_str(s, 1'b0, ge, gs);
      total++;
      if ({ge, gs} !== {me, ms}) begin bad++; $display("FAIL rand%0d_events got=%h exp=%h", n, {ge, gs}, {me, ms}); end
      total++;
      if ({bus.dtype, bus.op, bus.src1, bus.src2} !== {e_dtype, e_op, e_src1, e_src2})
        begin bad++; $display("FAIL rand%0d_fields got=%h exp=%h", n,
          {bus.dtype, bus.op, bus.src1, bus.src2}, {e_dtype, e_op, e_src1, e_src2}); end
      if (mbusy) begin
        do_done($urandom_range(1, 10), cd, bz, fe);
        mbusy = 1'b0;
        total++;
        if ({cd, bz, fe} !== 3'b100) begin bad++; $display("FAIL rand%0d_done got=%b exp=100", n, {cd, bz, fe}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] me, ms, ge, gs;
    logic cd, bz, fe;
    send_str("W1234-00", 1'b0, ge, gs);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err} !== 45'h0)
      begin bad++; $display("FAIL rst_src2 got=%h exp=0",
        {bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err}); end
    @(negedge clk);
    n_rst = 1'b1;
    model_str("02=", me, ms);
    send_str("02=", 1'b0, ge, gs);
    total++;
    if ({ge, gs} !== {me, ms} || bus.busy !== 1'b0)
      begin bad++; $display("FAIL rst_tail got=%h busy=%b exp=%h busy=0", {ge, gs}, bus.busy, {me, ms}); end
    model_str("S7FFF+8001=", me, ms);
    send_str("S7FFF+8001=", 1'b0, ge, gs);
    total++;
    if (gs !== ms || ms !== 32'h400) begin bad++; $display("FAIL rst_refill got=%h exp=%h", gs, ms); end
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err} !== 45'h0)
      begin bad++; $display("FAIL rst_wait got=%h exp=0",
        {bus.dtype, bus.op, bus.src1, bus.src2, bus.start, bus.busy, bus.cmd_done, bus.frame_err}); end
    @(negedge clk);
    n_rst = 1'b1;
    do_done(1, cd, bz, fe);
    total++;
    if ({cd, bz, fe, bus.start} !== 4'b0000) begin bad++; $display("FAIL rst_wait_after got=%b exp=0000", {cd, bz, fe, bus.start}); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.alu_done = 1'b0;
    test_reset();
    test_basic("W00FF+0001=", "basic");
    test_basic("SfffE/0003=", "mixed_case");
    test_parse_error();
    test_crlf_and_drop();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
